// File: rtl/fifo_read_port.sv
// Read side of the UART byte FIFO: tracks RAM occupancy, fetches from a
// synchronous-read RAM and presents bytes first-word-fall-through via a 2-entry buffer.
module fifo_read_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_commit,
  output logic                  f_full,
  output logic                  f_empty,
  output logic [ADDR_WIDTH+1:0] fill_level,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ovf_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  ovf_err_q, ovf_err_d;

  logic       full;
  logic       pop;
  logic       fetch;
  logic       commit_ok;
  logic [1:0] occ_after_pop;

  always_comb begin
    full      = (mem_count_q == DEPTH_C);
    pop       = (buf_count_q != 2'd0) && rd_ready;
    // buf_count + inflight never exceeds 2 and pop implies buf_count >= 1,
    // so this 2-bit sum neither overflows nor underflows.
    occ_after_pop = buf_count_q + {1'b0, inflight_q} - {1'b0, pop};
    fetch     = (mem_count_q != '0) && (occ_after_pop < 2'd2);
    commit_ok = wr_commit && !full;

    mem_count_d = mem_count_q;
    if (commit_ok && !fetch) begin
      mem_count_d = mem_count_q + 1'b1;
    end else if (!commit_ok && fetch) begin
      mem_count_d = mem_count_q - 1'b1;
    end

    rd_ptr_d   = fetch ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    inflight_d = fetch;
    ovf_err_d  = ovf_err_q | (wr_commit & full);

    head_d      = head_q;
    tail_d      = tail_q;
    buf_count_d = buf_count_q;
    case ({inflight_q, pop})
      2'b01: begin
        head_d      = tail_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b10: begin
        if (buf_count_q == 2'd0) begin
          head_d = mem_rdata;
        end else begin
          tail_d = mem_rdata;
        end
        buf_count_d = buf_count_q + 2'd1;
      end
      2'b11: begin
        // Capture replaces the popped entry; count stays the same.
        if (buf_count_q == 2'd1) begin
          head_d = mem_rdata;
        end else begin
          head_d = tail_q;
          tail_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      rd_ptr_q    <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign f_full     = full;
  assign f_empty    = (mem_count_q == '0) && !inflight_q && (buf_count_q == 2'd0);
  assign fill_level = {1'b0, mem_count_q} + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
                    + {{ADDR_WIDTH{1'b0}}, buf_count_q};
  assign mem_rd_en  = fetch;
  assign rd_ptr     = rd_ptr_q;
  assign rd_valid   = (buf_count_q != 2'd0);
  assign rd_data    = head_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_fifo_read_port.sv
// Randomized bench for fifo_read_port: a RAM/write-side model feeds the DUT and a
// queue-based reference model predicts every output each cycle.
module tb_fifo_read_port;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_commit;
  logic          f_full;
  logic          f_empty;
  logic [AW+1:0] fill_level;
  logic          mem_rd_en;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] mem_rdata;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          ovf_err;

  logic [DW-1:0] wr_data;

  fifo_read_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_commit  (wr_commit),
    .f_full     (f_full),
    .f_empty    (f_empty),
    .fill_level (fill_level),
    .mem_rd_en  (mem_rd_en),
    .rd_ptr     (rd_ptr),
    .mem_rdata  (mem_rdata),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  // Write side and synchronous-read RAM; idle read cycles return junk.
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] wptr;
  always @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
    end else if (wr_commit && !f_full) begin
      ram[wptr] <= wr_data;
      wptr      <= wptr + 1'b1;
    end
    mem_rdata <= mem_rd_en ? ram[rd_ptr] : 8'($urandom);
  end

  // Reference model: bytes in RAM, the byte in flight, and the output buffer.
  logic [DW-1:0] m_memq[$];
  logic [DW-1:0] m_buf[$];
  logic          m_inf;
  logic [DW-1:0] m_inf_byte;
  int            m_rptr;
  logic          m_ovf;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_memq.delete();
    m_buf.delete();
    m_inf      = 1'b0;
    m_inf_byte = '0;
    m_rptr     = 0;
    m_ovf      = 1'b0;
  endtask

  // Check outputs against the model, advance one clock, update the model.
  task automatic tick();
    logic e_full, e_pop, e_fetch;
    int   occ;
    #1;
    e_full  = (m_memq.size() == DEPTH);
    e_pop   = (m_buf.size() > 0) && rd_ready;
    occ     = m_buf.size() + int'(m_inf) - int'(e_pop);
    e_fetch = (m_memq.size() > 0) && (occ < 2);
    check("rd_valid", rd_valid, m_buf.size() > 0);
    if (m_buf.size() > 0) check("rd_data", rd_data, m_buf[0]);
    check("mem_rd_en", mem_rd_en, e_fetch);
    if (e_fetch) check("rd_ptr", rd_ptr, m_rptr);
    check("f_full", f_full, e_full);
    check("f_empty", f_empty, (m_memq.size() == 0) && !m_inf && (m_buf.size() == 0));
    check("fill_level", fill_level, m_memq.size() + int'(m_inf) + m_buf.size());
    check("ovf_err", ovf_err, m_ovf);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_pop) void'(m_buf.pop_front());
      if (m_inf) m_buf.push_back(m_inf_byte);
      if (e_fetch) m_inf_byte = m_memq.pop_front();
      m_inf = e_fetch;
      if (wr_commit && !e_full) m_memq.push_back(wr_data);
      if (wr_commit && e_full) m_ovf = 1'b1;
      if (e_fetch) m_rptr = (m_rptr + 1) % DEPTH;
    end
    #1;
  endtask

  task automatic idle(input int n);
    wr_commit = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int commit_pct, ready_pct;
    rst = 1'b1; wr_commit = 1'b0; rd_ready = 1'b0; wr_data = '0;
    @(posedge clk); #1;
    model_reset();
    tick();
    check("rst_f_empty", f_empty, 1'b1);
    check("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;

    // Single write, latency three edges.
    wr_commit = 1'b1; wr_data = 8'h5A;
    tick();
    wr_commit = 1'b0;
    #1;
    check("lat_rd_en", mem_rd_en, 1'b1);
    check("lat_rd_ptr", rd_ptr, 0);
    tick(); tick();
    check("lat_valid", rd_valid, 1'b1);
    check("lat_data", rd_data, 8'h5A);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pop_f_empty", f_empty, 1'b1);

    // Streaming with rd_ptr wrap.
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_commit = 1'b1; wr_data = 8'(i);
      tick();
    end
    idle(6);
    check("stream_empty", f_empty, 1'b1);

    // Back-pressure to full, then overflow.
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_commit = 1'b1; wr_data = 8'($urandom);
      tick();
    end
    idle(3);
    check("bp_full", f_full, 1'b1);
    check("bp_fill", fill_level, 18);
    wr_commit = 1'b1; wr_data = 8'hEE;
    tick();
    idle(2);
    check("ovf_set", ovf_err, 1'b1);
    check("ovf_fill", fill_level, 18);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    check("full_drop", f_full, 1'b0);
    idle(2);
    check("ovf_sticky", ovf_err, 1'b1);

    // Simultaneous commit, fetch and pop with mem_count=3, buf_count=1.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_commit = 1'b1; wr_data = 8'(8'h30 + i);
      tick();
    end
    idle(3);
    rd_ready = 1'b1;
    tick();
    check("sim_pre_fill", fill_level, 5);
    wr_commit = 1'b1; wr_data = 8'h77;
    tick();
    wr_commit = 1'b0; rd_ready = 1'b0;
    check("sim_post_fill", fill_level, 5);
    rd_ready = 1'b1;
    idle(8);
    check("sim_drained", f_empty, 1'b1);

    // Reset mid-stream with a fetch in flight.
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_commit = 1'b1; wr_data = 8'($urandom);
      tick();
    end
    wr_commit = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", rd_valid, 1'b0);
    check("mrst_fill", fill_level, 0);
    check("mrst_empty", f_empty, 1'b1);
    idle(3);
    check("mrst_no_stale", rd_valid, 1'b0);

    // Randomized traffic with varying rates and occasional reset.
    commit_pct = 50; ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        commit_pct = $urandom_range(10, 100);
        ready_pct  = $urandom_range(0, 100);
      end
      rst       = ($urandom_range(0, 399) == 0);
      wr_commit = ($urandom_range(0, 99) < commit_pct);
      if (m_memq.size() == DEPTH && $urandom_range(0, 9) != 0) wr_commit = 1'b0;
      rd_ready  = ($urandom_range(0, 99) < ready_pct);
      wr_data   = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    rd_ready = 1'b1;
    idle(DEPTH + 6);
    check("final_empty", f_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
